// File: rtl/thinkgear_parser.sv
// ThinkGear packet parser: turns the headset UART byte stream into attention,
// meditation and poor-signal values, committed only when a packet's checksum passes.
module thinkgear_parser #(
  parameter int TIMEOUT_CYC = 500000,
  parameter int MAX_PLEN    = 169
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] attention_data,
  output logic [7:0] meditation_data,
  output logic [7:0] poor_signal,
  output logic       data_update,
  output logic       checksum_err
);

  typedef enum logic [2:0] {
    SYNC1, SYNC2, PLEN, CODE, VAL1, VLEN, SKIP, CHK
  } state_t;

  localparam int         TW         = $clog2(TIMEOUT_CYC + 1);
  localparam logic [7:0] MAX_PLEN_B = 8'(MAX_PLEN);
  localparam logic [7:0] SYNC_BYTE  = 8'hAA;
  localparam logic [7:0] EXCODE     = 8'h55;

  state_t        state;
  state_t        payload_next;
  logic [TW-1:0] timer;
  logic [7:0]    plen;
  logic [7:0]    count;
  logic [7:0]    sum;
  logic [7:0]    code;
  logic [7:0]    skip_n;
  logic [7:0]    att_sh;
  logic [7:0]    med_sh;
  logic [7:0]    poor_sh;
  logic          att_p;
  logic          med_p;
  logic          poor_p;

  logic [7:0] sum_nxt;
  logic [7:0] count_nxt;
  logic       last_payload;

  assign sum_nxt      = sum + rx_data;
  assign count_nxt    = count + 8'd1;
  // Reaching the declared length forces the checksum next, whatever sub-state we are in.
  assign last_payload = (count_nxt == plen);

  // NOTE: combinational next-state gets a default first so no path infers a latch.
  always_comb begin
    payload_next = CODE;
    case (state)
      CODE: begin
        if (rx_data == EXCODE)     payload_next = CODE;
        else if (rx_data < 8'h80)  payload_next = VAL1;
        else                       payload_next = VLEN;
      end
      VLEN:    payload_next = (rx_data == 8'd0) ? CODE : SKIP;
      SKIP:    payload_next = (skip_n == 8'd1) ? CODE : SKIP;
      default: payload_next = CODE;
    endcase
  end

  // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= SYNC1;
      timer           <= '0;
      plen            <= '0;
      count           <= '0;
      sum             <= '0;
      code            <= '0;
      skip_n          <= '0;
      att_sh          <= '0;
      med_sh          <= '0;
      poor_sh         <= '0;
      att_p           <= 1'b0;
      med_p           <= 1'b0;
      poor_p          <= 1'b0;
      attention_data  <= '0;
      meditation_data <= '0;
      poor_signal     <= 8'hC8;
      data_update     <= 1'b0;
      checksum_err    <= 1'b0;
    end else begin
      data_update  <= 1'b0;
      checksum_err <= 1'b0;

      if (rx_valid || state == SYNC1) begin
        timer <= '0;
      end else if (timer == TW'(TIMEOUT_CYC - 1)) begin
        timer <= '0;
        state <= SYNC1;
      end else begin
        timer <= timer + 1'b1;
      end

      if (rx_valid) begin
        case (state)
          SYNC1: if (rx_data == SYNC_BYTE) state <= SYNC2;
          SYNC2: state <= (rx_data == SYNC_BYTE) ? PLEN : SYNC1;
          PLEN: begin
            if (rx_data == SYNC_BYTE) begin
              state <= PLEN;
            end else if (rx_data > MAX_PLEN_B) begin
              state <= SYNC1;
            end else begin
              plen   <= rx_data;
              sum    <= '0;
              count  <= '0;
              att_p  <= 1'b0;
              med_p  <= 1'b0;
              poor_p <= 1'b0;
              state  <= (rx_data == 8'd0) ? CHK : CODE;
            end
          end
          CHK: begin
            if (rx_data == ~sum) begin
              data_update <= 1'b1;
              if (att_p)  attention_data  <= att_sh;
              if (med_p)  meditation_data <= med_sh;
              if (poor_p) poor_signal     <= poor_sh;
            end else begin
              checksum_err <= 1'b1;
            end
            state <= SYNC1;
          end
          default: begin
            sum   <= sum_nxt;
            count <= count_nxt;
            case (state)
              CODE: code <= rx_data;
              VAL1: begin
                case (code)
                  8'h02: begin poor_sh <= rx_data; poor_p <= 1'b1; end
                  8'h04: begin att_sh  <= rx_data; att_p  <= 1'b1; end
                  8'h05: begin med_sh  <= rx_data; med_p  <= 1'b1; end
                  default: ;
                endcase
              end
              VLEN:    skip_n <= rx_data;
              SKIP:    skip_n <= skip_n - 8'd1;
              default: ;
            endcase
            state <= last_payload ? CHK : payload_next;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_thinkgear_parser.sv
// Scoreboard bench for thinkgear_parser: directed packets push expected pulses/values,
// a negedge monitor pops and compares whenever the DUT pulses.
module tb_thinkgear_parser;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic       upd;
    logic [7:0] att;
    logic [7:0] med;
    logic [7:0] poor;
  } exp_t;

  localparam int TMO = 200;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic [7:0] attention_data;
  logic [7:0] meditation_data;
  logic [7:0] poor_signal;
  logic       data_update;
  logic       checksum_err;

  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  thinkgear_parser #(.TIMEOUT_CYC(TMO), .MAX_PLEN(169)) dut (
    .clk             (clk),
    .rst             (rst),
    .rx_data         (rx_data),
    .rx_valid        (rx_valid),
    .attention_data  (attention_data),
    .meditation_data (meditation_data),
    .poor_signal     (poor_signal),
    .data_update     (data_update),
    .checksum_err    (checksum_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_pkt(input bq_t q);
    foreach (q[i]) send(q[i]);
    repeat (3) @(negedge clk);
  endtask

  task automatic expect_pulse(input logic upd, input logic [7:0] att,
                              input logic [7:0] med, input logic [7:0] poor);
    exp_t e;
    e.upd = upd; e.att = att; e.med = med; e.poor = poor;
    sb.push_back(e);
  endtask

  // Monitor: every pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst && (data_update || checksum_err)) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", {30'd0, data_update, checksum_err}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("data_update", data_update, e.upd);
        check("checksum_err", checksum_err, !e.upd);
        check("attention", attention_data, e.att);
        check("meditation", meditation_data, e.med);
        check("poor_signal", poor_signal, e.poor);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_attention", attention_data, 8'h00);
    check("rst_meditation", meditation_data, 8'h00);
    check("rst_poor", poor_signal, 8'hC8);
    check("rst_pulses", {data_update, checksum_err}, 2'b00);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Basic packet: poor=0x20, attention=0x50
    expect_pulse(1'b1, 8'h50, 8'h00, 8'h20);
    send_pkt('{8'hAA, 8'hAA, 8'h04, 8'h02, 8'h20, 8'h04, 8'h50, 8'h89});

    // Bad checksums leave outputs alone, then a fresh valid packet is parsed
    expect_pulse(1'b0, 8'h50, 8'h00, 8'h20);
    send_pkt('{8'hAA, 8'hAA, 8'h04, 8'h02, 8'h20, 8'h04, 8'h50, 8'h88});
    expect_pulse(1'b0, 8'h50, 8'h00, 8'h20);
    send_pkt('{8'hAA, 8'hAA, 8'h04, 8'h02, 8'h30, 8'h04, 8'h60, 8'h68});
    expect_pulse(1'b1, 8'h60, 8'h00, 8'h30);
    send_pkt('{8'hAA, 8'hAA, 8'h04, 8'h02, 8'h30, 8'h04, 8'h60, 8'h69});

    // Raw-wave-only packet, then extra sync byte before PLEN
    expect_pulse(1'b1, 8'h60, 8'h00, 8'h30);
    send_pkt('{8'hAA, 8'hAA, 8'h04, 8'h80, 8'h02, 8'h12, 8'h34, 8'h37});
    expect_pulse(1'b1, 8'h60, 8'h3C, 8'h30);
    send_pkt('{8'hAA, 8'hAA, 8'hAA, 8'h02, 8'h05, 8'h3C, 8'hBE});

    // Oversize PLEN dropped silently, then attention=0x64
    send_pkt('{8'hAA, 8'hAA, 8'hAB});
    expect_pulse(1'b1, 8'h64, 8'h3C, 8'h30);
    send_pkt('{8'hAA, 8'hAA, 8'h02, 8'h04, 8'h64, 8'h97});

    // Extended-code byte and an unknown single-byte code
    expect_pulse(1'b1, 8'h70, 8'h3C, 8'h30);
    send_pkt('{8'hAA, 8'hAA, 8'h05, 8'h55, 8'h04, 8'h70, 8'h03, 8'h11, 8'h22});

    // VLEN of 8 truncated by PLEN=5 after one skipped byte
    expect_pulse(1'b1, 8'h70, 8'h44, 8'h30);
    send_pkt('{8'hAA, 8'hAA, 8'h05, 8'h05, 8'h44, 8'h83, 8'h08, 8'hAB, 8'h80});

    // Zero-length payload
    expect_pulse(1'b1, 8'h70, 8'h44, 8'h30);
    send_pkt('{8'hAA, 8'hAA, 8'h00, 8'hFF});

    // Inter-byte timeout abandons the partial packet without a pulse
    send_pkt('{8'hAA, 8'hAA, 8'h04, 8'h02});
    repeat (TMO + 1) @(negedge clk);
    expect_pulse(1'b1, 8'h50, 8'h44, 8'h20);
    send_pkt('{8'hAA, 8'hAA, 8'h04, 8'h02, 8'h20, 8'h04, 8'h50, 8'h89});

    // Reset mid-payload
    send(8'hAA); send(8'hAA); send(8'h04); send(8'h02); send(8'h20);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_attention", attention_data, 8'h00);
    check("midrst_meditation", meditation_data, 8'h00);
    check("midrst_poor", poor_signal, 8'hC8);
    check("midrst_pulses", {data_update, checksum_err}, 2'b00);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    expect_pulse(1'b1, 8'h50, 8'h00, 8'h20);
    send_pkt('{8'hAA, 8'hAA, 8'h04, 8'h02, 8'h20, 8'h04, 8'h50, 8'h89});

    repeat (5) @(negedge clk);
    check("sb_drain", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
